// File: rtl/instr_mem_pkg.sv
// Shared types for the instruction fetch memory: control states and fault encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside a fault_t.
    localparam int FAULT_MISALIGN_BIT = 0;
    localparam int FAULT_RANGE_BIT    = 1;

    typedef logic [1:0] fault_t;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DATA_W x DEPTH, one synchronous write port, one synchronous read port.
// Latency: rdata valid the cycle after re; holds its value until the next re.
// Backpressure: none; writes and reads are accepted every cycle.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset: contents survive rst. rdata only moves on re, so an accepted
    // fetch keeps its snapshot even if the word is rewritten afterwards.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: single-outstanding fetch with address fault decode and counters.
// Latency: accept -> rsp_valid in READ_LAT (1 or 2) cycles; one bubble between responses.
// Backpressure: response held stable until rsp_ready; req_ready low unless idle and no prog write.
// Ports: clk/rst; req_valid/req_ready/req_addr fetch request; rsp_valid/rsp_ready/rsp_instr/
//        rsp_fault response; prog_we/prog_addr/prog_data program port; fetch_count/fault_count.
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 64,
    parameter int                READ_LAT    = 1,
    parameter logic [DATA_W-1:0] FAULT_INSTR = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_instr,
    output logic [1:0]               rsp_fault,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [31:0]              fetch_count,
    output logic [15:0]              fault_count
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    state_t            state_nxt;
    fault_t            fault_dec;
    fault_t            fault_q;
    logic              accept;
    logic              rsp_hs;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    // Word index is req_addr[31:2]; any set bit above the index width is out of range.
    assign fault_dec[FAULT_MISALIGN_BIT] = |req_addr[1:0];
    assign fault_dec[FAULT_RANGE_BIT]    = |req_addr[31:AW+2];

    // Program writes win over fetch acceptance.
    assign req_ready = (state == ST_IDLE) && !prog_we && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_hs    = rsp_valid && rsp_ready;

    // Faulted fetches never touch the array.
    assign mem_re = accept && (fault_dec == '0);

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_imem_array (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re),
        .raddr (req_addr[AW+1:2]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (READ_LAT == 2) ? ST_READ : ST_RESP;
            ST_READ: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= '0;
        end else if (accept) begin
            fault_q <= fault_dec;
        end
    end

    // Outputs are forced to zero outside RESP, which also gives the immediate
    // clear on rst since the state register resets asynchronously.
    assign rsp_fault = rsp_valid ? fault_q : '0;
    assign rsp_instr = !rsp_valid      ? '0          :
                       (fault_q != '0) ? FAULT_INSTR : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= '0;
            fault_count <= '0;
        end else if (rsp_hs) begin
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((fault_q != '0) && (fault_count != '1)) begin
                fault_count <= fault_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: scoreboard-checked fetches on a READ_LAT=1 instance,
// latency and reset-in-flight checks on a READ_LAT=2 instance sharing clock, reset and program port.
// All comparisons go through check_eq.
module tb_instr_fetch_mem;

    localparam int          DW = 32;
    localparam int          DP = 64;
    localparam logic [31:0] FI = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;

    logic        req_valid1, req_ready1, rsp_valid1;
    logic [31:0] rsp_instr1, fetch_count1;
    logic [1:0]  rsp_fault1;
    logic [15:0] fault_count1;

    logic        req_valid2, req_ready2, rsp_valid2;
    logic [31:0] rsp_instr2, fetch_count2;
    logic [1:0]  rsp_fault2;
    logic [15:0] fault_count2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DP];
    logic [33:0] sb [$];

    always #5 clk = ~clk;

    instr_fetch_mem #(.DATA_W(DW), .DEPTH(DP), .READ_LAT(1), .FAULT_INSTR(FI)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr1), .rsp_fault(rsp_fault1),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_count(fetch_count1), .fault_count(fault_count1)
    );

    instr_fetch_mem #(.DATA_W(DW), .DEPTH(DP), .READ_LAT(2), .FAULT_INSTR(FI)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_addr(req_addr),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr2), .rsp_fault(rsp_fault2),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .fetch_count(fetch_count2), .fault_count(fault_count2)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for dut1: compare on every completed handshake.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && rsp_valid1 && rsp_ready) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_rsp", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("rsp_instr", rsp_instr1, e[31:0]);
                check_eq("rsp_fault", rsp_fault1, e[33:32]);
            end
        end
    end

    // Inputs are driven #1 after a rising edge; each task returns at that same phase.
    task automatic prog(input logic [5:0] idx, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = idx; prog_data = d;
        @(posedge clk); #1;
        prog_we = 1'b0;
        model_mem[idx] = d;
    endtask

    task automatic push_expect(input logic [31:0] addr);
        logic [1:0]  f;
        logic [31:0] ins;
        f[0] = (addr[1:0] != 2'b00);
        f[1] = ((addr >> 2) >= DP);
        ins  = (f != 2'b00) ? FI : model_mem[addr[7:2]];
        sb.push_back({f, ins});
    endtask

    task automatic fetch1(input logic [31:0] addr);
        int n = 0;
        req_valid1 = 1'b1; req_addr = addr;
        @(negedge clk);
        while (!req_ready1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready1) check_eq("accept_timeout", 0, 1);
        push_expect(addr);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        @(negedge clk);
        while (rsp_valid1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid1) check_eq("drain_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_addr = '0; rsp_ready = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_valid1 = 1'b0; req_valid2 = 1'b0;
        for (int i = 0; i < DP; i++) model_mem[i] = '0;

        // Reset state, with a request already pending.
        req_valid1 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rsp_valid", rsp_valid1, 0);
        check_eq("rst_rsp_instr", rsp_instr1, 0);
        check_eq("rst_rsp_fault", rsp_fault1, 0);
        check_eq("rst_req_ready", req_ready1, 0);
        check_eq("rst_fetch_count", fetch_count1, 0);
        check_eq("rst_fault_count", fault_count1, 0);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) prog(6'(i), 32'(i + 1));

        // Basic fetch, READ_LAT=1: valid the cycle after accept.
        fetch1(32'h8);
        @(negedge clk);
        check_eq("lat1_rsp_valid", rsp_valid1, 1);
        @(posedge clk); #1;
        drain1();
        check_eq("fetch_count_1", fetch_count1, 1);

        // Faults: misaligned, out of range, both.
        fetch1(32'h6);    drain1();
        fetch1(32'h100);  drain1();
        fetch1(32'h101);  drain1();
        check_eq("fault_count_3", fault_count1, 3);
        check_eq("fetch_count_4", fetch_count1, 4);

        // Backpressure: held response must not move or count.
        rsp_ready = 1'b0;
        fetch1(32'h4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_rsp_valid", rsp_valid1, 1);
            check_eq("hold_rsp_instr", rsp_instr1, 2);
            check_eq("hold_req_ready", req_ready1, 0);
            check_eq("hold_fetch_count", fetch_count1, 4);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        drain1();
        check_eq("fetch_count_5", fetch_count1, 5);

        // Write after accept does not disturb the in-flight word.
        fetch1(32'h8);
        prog(6'd2, 32'hDEAD);
        drain1();
        fetch1(32'h8);
        drain1();

        // Program writes block acceptance until they stop.
        req_valid1 = 1'b1; req_addr = 32'h0;
        prog_we = 1'b1; prog_addr = 6'd3; prog_data = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("prog_blocks_ready", req_ready1, 0);
            @(posedge clk); #1;
        end
        prog_we = 1'b0;
        @(negedge clk);
        check_eq("ready_after_prog", req_ready1, 1);
        push_expect(32'h0);
        @(posedge clk); #1;
        req_valid1 = 1'b0;
        drain1();
        check_eq("fetch_count_8", fetch_count1, 8);

        // READ_LAT=2 latency.
        req_valid2 = 1'b1; req_addr = 32'h4;
        @(negedge clk);
        check_eq("lat2_req_ready", req_ready2, 1);
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        @(negedge clk);
        check_eq("lat2_read_no_valid", rsp_valid2, 0);
        @(negedge clk);
        check_eq("lat2_rsp_valid", rsp_valid2, 1);
        check_eq("lat2_rsp_instr", rsp_instr2, 2);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("lat2_fetch_count", fetch_count2, 1);
        @(posedge clk); #1;

        // Reset while in READ discards the request and clears counters at once.
        req_valid2 = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rstmid_rsp_valid", rsp_valid2, 0);
        check_eq("rstmid_req_ready", req_ready2, 0);
        check_eq("rstmid_fetch_count2", fetch_count2, 0);
        check_eq("rstmid_fetch_count1", fetch_count1, 0);
        check_eq("rstmid_fault_count1", fault_count1, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid_discarded", rsp_valid2, 0);
        @(posedge clk); #1;
        req_valid2 = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mem_kept_valid", rsp_valid2, 1);
        check_eq("mem_kept_word0", rsp_instr2, 1);
        @(posedge clk); #1;
        repeat (2) @(posedge clk);

        check_eq("sb_all_consumed", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
